// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor
// Brief    : Checks a terminal-count counter's output for legal steps and
//            queues TC / WRAP / STEP_ERR / TIMEOUT events for a consumer.
// Revision : 1.0 - initial release
// ============================================================================
module count_monitor #(
    parameter int CW         = 4,
    parameter int MAX_VALUE  = 8,
    parameter int TIMEOUT    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] count_in,
    output logic          tc_pulse,
    output logic [7:0]    wrap_cnt,
    output logic          err,
    output logic          timeout,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [1:0]    evt_code,
    output logic          evt_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_max        = CW'(MAX_VALUE);
    localparam logic [SW-1:0] c_stall_last = SW'(TIMEOUT - 1);
    localparam logic [AW:0]   c_depth      = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   c_one        = (AW+1)'(1);

    localparam logic [1:0] c_evt_tc   = 2'b00;
    localparam logic [1:0] c_evt_wrap = 2'b01;
    localparam logic [1:0] c_evt_step = 2'b10;
    localparam logic [1:0] c_evt_tmo  = 2'b11;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_prev;
    logic [CW-1:0] w_prev_nxt;
    logic [SW-1:0] r_stall;
    logic [SW-1:0] w_stall_nxt;

    logic w_tc;
    logic w_wrap;
    logic w_step_err;
    logic w_tmo;
    logic w_legal;
    logic w_push;
    logic [1:0] w_code;

    logic [1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_rd_ptr_inc;
    logic [AW:0]   w_count_nxt;
    logic [1:0]    w_head_nxt;
    logic          w_pop;
    logic          w_full;
    logic          w_accept;
    logic          w_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
            r_prev  <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_stall_nxt = r_stall;
        w_tc        = 1'b0;
        w_wrap      = 1'b0;
        w_step_err  = 1'b0;
        w_tmo       = 1'b0;
        w_legal     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                w_prev_nxt  = count_in;
                w_state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                w_prev_nxt = count_in;
                // A captured out-of-range value can never make a hold legal.
                w_legal = (count_in <= c_max) &&
                          ((count_in == r_prev) ||
                           ((r_prev < c_max) && (count_in == r_prev + 1'b1)) ||
                           ((r_prev == c_max) && (count_in == '0)));
                w_step_err = !w_legal;
                w_tc       = (count_in == c_max) && (r_prev != c_max);
                w_wrap     = (r_prev == c_max) && (count_in == '0);
                if (w_tc) begin
                    w_stall_nxt = '0;
                end else if (r_stall == c_stall_last) begin
                    w_tmo       = 1'b1;
                    w_stall_nxt = '0;
                end else begin
                    w_stall_nxt = r_stall + 1'b1;
                end
                if (w_step_err) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    always_comb begin
        w_push = w_step_err | w_tc | w_wrap | w_tmo;
        if (w_step_err) begin
            w_code = c_evt_step;
        end else if (w_tc) begin
            w_code = c_evt_tc;
        end else if (w_wrap) begin
            w_code = c_evt_wrap;
        end else begin
            w_code = c_evt_tmo;
        end
    end

    assign w_pop        = evt_valid && evt_ready;
    assign w_full       = (r_count == c_depth);
    assign w_accept     = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_comb begin
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Head is kept in a register so evt_code is a flop output, not a mux.
    always_comb begin
        w_head_nxt = evt_code;
        if (r_count == '0) begin
            if (w_accept) begin
                w_head_nxt = w_code;
            end
        end else if (w_pop) begin
            if (r_count == c_one) begin
                w_head_nxt = w_code;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            evt_valid    <= 1'b0;
            evt_code     <= 2'b00;
            evt_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count      <= w_count_nxt;
            evt_valid    <= (w_count_nxt != '0);
            evt_code     <= w_head_nxt;
            evt_overflow <= evt_overflow | w_drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_pulse <= 1'b0;
            wrap_cnt <= 8'd0;
            err      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            tc_pulse <= w_tc;
            if (w_wrap && (wrap_cnt != 8'hFF)) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
            err     <= err | w_step_err;
            timeout <= timeout | w_tmo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_monitor
// Brief    : Self-checking bench for count_monitor: directed tables, corner
//            sequences and randomized traffic against an event-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

    localparam int CW    = 4;
    localparam int MAXV  = 8;
    localparam int TMO   = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count_in;
    logic          evt_ready;
    logic          tc_pulse;
    logic [7:0]    wrap_cnt;
    logic          err;
    logic          timeout;
    logic          evt_valid;
    logic [1:0]    evt_code;
    logic          evt_overflow;

    always #5 clk = ~clk;

    count_monitor #(
        .CW(CW), .MAX_VALUE(MAXV), .TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .tc_pulse(tc_pulse),
        .wrap_cnt(wrap_cnt), .err(err), .timeout(timeout), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_overflow(evt_overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = sync, 1 = track, 2 = fault.
    int m_mode, m_prev, m_stall, m_wrap;
    bit m_err, m_tmo, m_ovf, m_tc;
    int m_q[$];

    function automatic void m_reset();
        m_mode = 0; m_prev = 0; m_stall = 0; m_wrap = 0;
        m_err = 0; m_tmo = 0; m_ovf = 0; m_tc = 0;
        m_q.delete();
    endfunction

    function automatic void m_edge(int c, bit rdy);
        int  sz  = m_q.size();
        bit  pop = (sz > 0) && rdy;
        int  ev  = -1;
        bit  legal, tc, wr, to;
        m_tc = 0;
        if (m_mode == 0) begin
            m_prev = c;
            m_mode = 1;
        end else if (m_mode == 1) begin
            legal = (c <= MAXV) && ((c == m_prev) ||
                    (m_prev < MAXV && c == m_prev + 1) ||
                    (m_prev == MAXV && c == 0));
            tc = (c == MAXV) && (m_prev != MAXV);
            wr = (m_prev == MAXV) && (c == 0);
            to = 0;
            if (tc) m_stall = 0;
            else begin
                m_stall++;
                if (m_stall == TMO) begin to = 1; m_stall = 0; end
            end
            m_tc = tc;
            if (wr && m_wrap < 255) m_wrap++;
            if (to) m_tmo = 1;
            if (!legal) begin m_err = 1; m_mode = 2; end
            m_prev = c;
            ev = !legal ? 2 : tc ? 0 : wr ? 1 : to ? 3 : -1;
        end
        if (pop) void'(m_q.pop_front());
        if (ev >= 0) begin
            if (sz < DEPTH || pop) m_q.push_back(ev);
            else m_ovf = 1;
        end
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("tc_pulse", tc_pulse, m_tc);
        chk("wrap_cnt", wrap_cnt, m_wrap);
        chk("err", err, m_err);
        chk("timeout", timeout, m_tmo);
        chk("evt_overflow", evt_overflow, m_ovf);
        chk("evt_valid", evt_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("evt_code", evt_code, m_q[0]);
    endtask

    task automatic step(int c, bit rdy);
        count_in  = c[CW-1:0];
        evt_ready = rdy;
        @(posedge clk);
        if (!reset) m_edge(c, rdy);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic ramp(int lo, int hi, bit rdy);
        for (int v = lo; v <= hi; v++) step(v, rdy);
    endtask

    typedef struct {
        int cnt;
        bit tc;
        bit valid;
        int code;
        int wrapc;
    } vec_t;
    vec_t tv[$];

    function automatic void add(int cnt, bit tc, bit valid, int code, int wrapc);
        vec_t v;
        v.cnt = cnt; v.tc = tc; v.valid = valid; v.code = code; v.wrapc = wrapc;
        tv.push_back(v);
    endfunction

    initial begin
        int exp4[4];
        int n;
        int cur;
        int r;

        reset     = 1'b1;
        count_in  = '0;
        evt_ready = 1'b1;
        m_reset();

        // Test 1 expectations, derived by hand from the step rules.
        add(0, 0, 0, 0, 0);
        for (int v = 1; v <= 7; v++) add(v, 0, 0, 0, 0);
        add(8, 1, 1, 0, 0);
        add(0, 0, 1, 1, 1);
        for (int v = 1; v <= 7; v++) add(v, 0, 0, 0, 1);
        add(8, 1, 1, 0, 1);

        #1;
        chk("rst_tc", tc_pulse, 0);
        chk("rst_wrap", wrap_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_ovf", evt_overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 1: two full ramps
        foreach (tv[i]) begin
            step(tv[i].cnt, 1'b1);
            chk("t1_tc", tc_pulse, tv[i].tc);
            chk("t1_valid", evt_valid, tv[i].valid);
            if (tv[i].valid) chk("t1_code", evt_code, tv[i].code);
            chk("t1_wrap", wrap_cnt, tv[i].wrapc);
            chk("t1_err", err, 0);
        end

        // Test 2: step error then absorbing fault
        do_reset();
        step(3, 1); step(3, 1); step(5, 1);
        chk("t2_err", err, 1);
        chk("t2_valid", evt_valid, 1);
        chk("t2_code", evt_code, 2);
        for (int v = 6; v <= 8; v++) begin
            step(v, 1);
            chk("t2_no_tc", tc_pulse, 0);
            chk("t2_no_evt", evt_valid, 0);
        end

        // Test 3: stall timeout
        do_reset();
        step(2, 1);
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            step(2, 1);
            if (i == 31) chk("t3_tmo_early", timeout, 0);
            if (i == 32) chk("t3_tmo_set", timeout, 1);
            if (evt_valid && evt_code == 2'b11) n++;
        end
        chk("t3_tmo_events", n, 2);
        chk("t3_err", err, 0);

        // Test 4: overflow with a stalled consumer
        do_reset();
        step(0, 0);
        ramp(1, 8, 0); step(0, 0); ramp(1, 8, 0); step(0, 0);
        chk("t4_ovf_before", evt_overflow, 0);
        ramp(1, 8, 0);
        chk("t4_ovf", evt_overflow, 1);
        exp4 = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_valid", evt_valid, 1);
            chk("t4_drain_code", evt_code, exp4[k]);
            step(8, 1);
        end
        chk("t4_empty", evt_valid, 0);

        // Test 5: push into a full FIFO on the same cycle as a pop
        do_reset();
        step(0, 0);
        ramp(1, 8, 0); step(0, 0); ramp(1, 8, 0); step(0, 0);
        ramp(1, 7, 0);
        step(8, 1);
        chk("t5_ovf", evt_overflow, 0);
        chk("t5_tc", tc_pulse, 1);
        exp4 = '{1, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            chk("t5_drain_valid", evt_valid, 1);
            chk("t5_drain_code", evt_code, exp4[k]);
            step(8, 1);
        end
        chk("t5_empty", evt_valid, 0);

        // Test 6: asynchronous reset with a populated FIFO
        do_reset();
        step(0, 0);
        ramp(1, 8, 0); step(0, 0); step(5, 0);
        chk("t6_err_pre", err, 1);
        chk("t6_wrap_pre", wrap_cnt, 1);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        chk("t6_valid", evt_valid, 0);
        chk("t6_err", err, 0);
        chk("t6_wrap", wrap_cnt, 0);
        chk("t6_ovf", evt_overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(7, 1);
        chk("t6_sync_tc", tc_pulse, 0);
        chk("t6_sync_valid", evt_valid, 0);
        step(8, 1);
        chk("t6_tc", tc_pulse, 1);
        chk("t6_evt", evt_valid, 1);
        chk("t6_code", evt_code, 0);

        // Randomized traffic with occasional faults and mid-cycle resets
        cur = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 4) begin
                #2;
                reset = 1'b1;
                m_reset();
                #1;
                compare_model();
                @(posedge clk);
                #1;
                reset = 1'b0;
                cur = $urandom_range(0, MAXV);
            end else begin
                if (r < 12) cur = $urandom_range(0, 15);
                else if (r < 600) cur = (cur >= MAXV) ? 0 : cur + 1;
                else if (r < 620) begin
                    for (int h = 0; h < 40; h++) step(cur, $urandom_range(0, 3) != 0);
                end
                step(cur, $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
